// File: rtl/icache_refill_mmu.sv
// Instruction-side MMU: direct-mapped I-cache with multi-word lines and a
// critical-word-first refill FSM talking req/ack to instruction memory.
module icache_refill_mmu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINES  = 16,
  parameter int WORDS  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addy,
  input  logic              ren,
  input  logic              flush,
  output logic [DATA_W-1:0] dataout,
  output logic              nostall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);

  localparam int WORD_W = $clog2(WORDS);
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = ADDR_W - 2 - WORD_W - IDX_W;
  localparam int CNT_W  = WORD_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REFILL    = 2'd1,
    ST_FILL_DONE = 2'd2
  } state_t;

  state_t              state_r, state_s;

  logic [DATA_W-1:0]   data_r [LINES][WORDS];
  logic [TAG_W-1:0]    tag_r  [LINES];
  logic [LINES-1:0]    valid_r;

  logic [TAG_W-1:0]    tag_s;
  logic [IDX_W-1:0]    index_s;
  logic [WORD_W-1:0]   word_s;
  logic                hit_s;
  logic                unused_s;

  logic [TAG_W-1:0]    ltag_r;
  logic [IDX_W-1:0]    lindex_r;
  logic [WORD_W-1:0]   wptr_r;
  logic [WORD_W-1:0]   wptr_inc_s;
  logic [CNT_W-1:0]    cnt_r;
  logic                last_ack_s;

  logic                mem_req_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [31:0]         hit_cnt_r;
  logic [31:0]         miss_cnt_r;
  logic                nostall_s;
  logic [DATA_W-1:0]   dataout_s;

  assign tag_s      = addy[ADDR_W-1 -: TAG_W];
  assign index_s    = addy[2+WORD_W +: IDX_W];
  assign word_s     = addy[2 +: WORD_W];
  assign unused_s   = ^addy[1:0];
  assign hit_s      = valid_r[index_s] && (tag_r[index_s] == tag_s);
  assign wptr_inc_s = wptr_r + WORD_W'(1);
  assign last_ack_s = mem_ack && (cnt_r == CNT_W'(WORDS - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; flush aborts any refill in progress
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!flush && ren && !hit_s) begin
          state_s = ST_REFILL;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REFILL: begin
        if (flush) begin
          state_s = ST_IDLE;
        end else if (last_ack_s) begin
          state_s = ST_FILL_DONE;
        end else begin
          state_s = ST_REFILL;
        end
      end
      ST_FILL_DONE: state_s = ST_IDLE;
      default:      state_s = ST_IDLE;
    endcase
  end

  // Fetch-side outputs: combinational lookup, only ever valid in IDLE
  always_comb begin
    nostall_s = 1'b0;
    dataout_s = '0;
    if (!reset && state_r == ST_IDLE) begin
      nostall_s = !flush && (!ren || hit_s);
      if (ren && hit_s) begin
        dataout_s = data_r[index_s][word_s];
      end else begin
        dataout_s = '0;
      end
    end else begin
      nostall_s = 1'b0;
      dataout_s = '0;
    end
  end

  // Control datapath: valid bits, refill pointers, memory request, counters
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r    <= '0;
      ltag_r     <= '0;
      lindex_r   <= '0;
      wptr_r     <= '0;
      cnt_r      <= '0;
      mem_req_r  <= 1'b0;
      mem_addr_r <= '0;
      hit_cnt_r  <= 32'd0;
      miss_cnt_r <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (flush) begin
            valid_r <= '0;
          end else if (ren && !hit_s) begin
            // Invalidate now so a partially refilled line can never hit
            valid_r[index_s] <= 1'b0;
            ltag_r     <= tag_s;
            lindex_r   <= index_s;
            wptr_r     <= word_s;
            cnt_r      <= '0;
            mem_req_r  <= 1'b1;
            mem_addr_r <= {tag_s, index_s, word_s, 2'b00};
            miss_cnt_r <= miss_cnt_r + 32'd1;
          end else if (ren) begin
            hit_cnt_r  <= hit_cnt_r + 32'd1;
          end
        end
        ST_REFILL: begin
          if (flush) begin
            valid_r   <= '0;
            mem_req_r <= 1'b0;
          end else if (mem_ack) begin
            wptr_r     <= wptr_inc_s;
            cnt_r      <= cnt_r + CNT_W'(1);
            mem_addr_r <= {ltag_r, lindex_r, wptr_inc_s, 2'b00};
            if (last_ack_s) begin
              mem_req_r <= 1'b0;
            end
          end
        end
        ST_FILL_DONE: begin
          if (flush) begin
            valid_r <= '0;
          end else begin
            valid_r[lindex_r] <= 1'b1;
          end
        end
        default: begin
          mem_req_r <= 1'b0;
        end
      endcase
    end
  end

  // Line storage: words land on refill acks, the tag on a completed fill
  always_ff @(posedge clk) begin
    if (!reset && !flush && state_r == ST_REFILL && mem_ack) begin
      data_r[lindex_r][wptr_r] <= mem_rdata;
    end
    if (!reset && !flush && state_r == ST_FILL_DONE) begin
      tag_r[lindex_r] <= ltag_r;
    end
  end

  assign dataout  = dataout_s;
  assign nostall  = nostall_s;
  assign mem_req  = mem_req_r;
  assign mem_addr = mem_addr_r;
  assign hit_cnt  = hit_cnt_r;
  assign miss_cnt = miss_cnt_r;

endmodule

// File: tb/tb_icache_refill_mmu.sv
// Self-checking bench for icache_refill_mmu: directed vector table, hand-written
// refill corner cases and random fetches against a line-level cache model.
module tb_icache_refill_mmu;

  localparam int WORDS = 4;

  logic        clk;
  logic        reset;
  logic [31:0] addy;
  logic        ren;
  logic        flush;
  logic [31:0] dataout;
  logic        nostall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  icache_refill_mmu #(.ADDR_W(32), .DATA_W(32), .LINES(16), .WORDS(WORDS)) dut (
    .clk(clk), .reset(reset), .addy(addy), .ren(ren), .flush(flush),
    .dataout(dataout), .nostall(nostall), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int ack_mode = 0;   // 0: ack every cycle, 1: every 3rd cycle, 2: random
  int slow_ctr = 0;

  // Reference model: which line (addr>>6) each index holds, -1 = empty
  int          line_of [16];
  int unsigned m_hits;
  int unsigned m_misses;

  typedef struct {
    logic [31:0] addr;
    logic        exp_hit;
    int          exp_hits;
    int          exp_misses;
  } vec_t;
  vec_t vecs [6];

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic drive_mem();
    slow_ctr++;
    case (ack_mode)
      0:       mem_ack = mem_req;
      1:       mem_ack = mem_req && (slow_ctr % 3 == 0);
      default: mem_ack = mem_req && ($urandom_range(0, 2) == 0);
    endcase
    mem_rdata = memfn(mem_addr);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive_mem();
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) line_of[i] = -1;
  endtask

  // One fetch held until nostall; entered and left just after a posedge
  task automatic fetch(input logic [31:0] a, output int lat);
    bit          mhit;
    bit          done;
    int          nack;
    int          sw;
    logic [31:0] base;
    mhit = (line_of[a[7:4]] == int'(a >> 6));
    base = {a[31:4], 4'h0};
    sw   = int'(a[3:2]);
    ren  = 1'b1;
    addy = a;
    lat  = 0;
    done = 1'b0;
    nack = 0;
    for (int k = 0; k < 80 && !done; k++) begin
      @(negedge clk);
      if (nostall) begin
        done = 1'b1;
        chk("dataout", dataout, memfn({a[31:2], 2'b00}));
        chk("mem_req_on_hit", mem_req, 1'b0);
        if (mhit || ack_mode == 0)
          chk("latency", 32'(lat), mhit ? 32'd0 : 32'(WORDS + 2));
      end else begin
        if (mem_req) begin
          chk("mem_addr", mem_addr, base + 32'(((sw + nack) % WORDS) * 4));
          if (mem_ack) nack++;
        end
        tick();
        lat++;
      end
    end
    if (!done) chk("fetch_timeout", 1'b0, 1'b1);
    if (!mhit) chk("words_fetched", 32'(nack), 32'(WORDS));
    tick();
    if (!mhit) m_misses++;
    m_hits++;
    line_of[a[7:4]] = int'(a >> 6);
    chk("hit_cnt", hit_cnt, m_hits);
    chk("miss_cnt", miss_cnt, m_misses);
  endtask

  task automatic abort_refill(input logic [31:0] a, input bit use_reset);
    int lat;
    ren = 1'b1;
    addy = a;
    tick();            // miss accepted, refill starts
    tick();            // first ack consumed
    tick();            // second ack consumed
    ren = 1'b0;
    if (use_reset) reset = 1'b1; else flush = 1'b1;
    @(negedge clk);
    chk("abort_nostall", nostall, 1'b0);
    chk("abort_dataout", dataout, 32'd0);
    tick();
    reset = 1'b0;
    flush = 1'b0;
    mem_ack = 1'b0;
    m_misses++;
    model_clear();
    if (use_reset) begin
      m_hits = 0;
      m_misses = 0;
    end
    @(negedge clk);
    chk("abort_mem_req", mem_req, 1'b0);
    chk("abort_idle_nostall", nostall, 1'b1);
    chk("abort_hit_cnt", hit_cnt, m_hits);
    chk("abort_miss_cnt", miss_cnt, m_misses);
    tick();
    fetch(a, lat);
    chk("abort_remiss", 32'(lat), 32'(WORDS + 2));
  endtask

  initial begin
    int lat;
    logic [31:0] a;
    reset = 1'b1; ren = 1'b0; flush = 1'b0; addy = 32'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    m_hits = 0; m_misses = 0;
    model_clear();

    vecs[0] = '{32'h0000_0108, 1'b0, 1, 1};   // cold miss
    vecs[1] = '{32'h0000_0100, 1'b1, 2, 1};   // hits on consecutive cycles
    vecs[2] = '{32'h0000_0104, 1'b1, 3, 1};
    vecs[3] = '{32'h0000_010C, 1'b1, 4, 1};
    vecs[4] = '{32'h0000_0508, 1'b0, 5, 2};   // conflict, same index
    vecs[5] = '{32'h0000_0108, 1'b0, 6, 3};   // evicted line misses again

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_nostall", nostall, 1'b0);
    chk("reset_dataout", dataout, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive_mem();
    @(negedge clk);
    chk("reset_mem_req", mem_req, 1'b0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_hit_cnt", hit_cnt, 32'd0);
    chk("reset_miss_cnt", miss_cnt, 32'd0);
    chk("idle_nostall", nostall, 1'b1);
    tick();

    for (int i = 0; i < 6; i++) begin
      fetch(vecs[i].addr, lat);
      chk("vec_hit", (lat == 0), vecs[i].exp_hit);
      chk("vec_hit_cnt", hit_cnt, 32'(vecs[i].exp_hits));
      chk("vec_miss_cnt", miss_cnt, 32'(vecs[i].exp_misses));
    end

    // Slow memory: address must hold until each ack, then all four words hit
    ack_mode = 1;
    fetch(32'h0000_06C8, lat);
    ack_mode = 0;
    fetch(32'h0000_06C0, lat);
    fetch(32'h0000_06C4, lat);
    fetch(32'h0000_06CC, lat);

    abort_refill(32'h0000_03C4, 1'b0);
    abort_refill(32'h0000_03C4, 1'b1);

    // ren=0 with a stray ack in IDLE: nothing counted, nothing written
    ren = 1'b0;
    addy = $urandom;
    mem_ack = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("ren0_nostall", nostall, 1'b1);
    chk("ren0_dataout", dataout, 32'd0);
    tick();
    @(negedge clk);
    chk("ren0_hit_cnt", hit_cnt, m_hits);
    chk("ren0_miss_cnt", miss_cnt, m_misses);
    tick();
    fetch(32'h0000_03C4, lat);
    fetch(32'h0000_03C0, lat);

    // Random traffic over a small address pool so lines get reused
    for (int n = 0; n < 160; n++) begin
      int r;
      r = int'($urandom_range(0, 11));
      if (r == 0) begin
        ren = 1'b0;
        flush = 1'b1;
        addy = $urandom;
        @(negedge clk);
        chk("flush_nostall", nostall, 1'b0);
        tick();
        flush = 1'b0;
        model_clear();
      end else if (r == 1) begin
        ren = 1'b0;
        addy = $urandom;
        @(negedge clk);
        chk("idle_nostall", nostall, 1'b1);
        chk("idle_dataout", dataout, 32'd0);
        tick();
      end else begin
        a = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 15)) << 4)
          | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
        ack_mode = int'($urandom_range(0, 2));
        fetch(a, lat);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
